// File: rtl/ddr2dvp_stream_if.sv
// DDR read-path handshake carrying 64-bit RAW words into the DVP playback block.
interface ddr2dvp_stream_if;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;

    modport master (output rd_data, output rd_valid, input rd_ready);
    modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/ddr2dvp_stream.sv
// Replays stored 64-bit RAW words as DVP VSYNC/HREF/D timing, LSB byte first,
// with a one-word prefetch buffer and a pix_ce-qualified frame timing generator.
module ddr2dvp_stream #(
    parameter int H_ACTIVE = 1280,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 720,
    parameter int VSYNC_W  = 3,
    parameter int V_BACK   = 17,
    parameter int V_FRONT  = 10
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   pix_ce,
    ddr2dvp_stream_if.slave        rd,
    output logic                   VSYNC,
    output logic                   HREF,
    output logic [7:0]             D,
    output logic                   SOF,
    output logic                   EOF,
    output logic [7:0]             count_frame,
    output logic                   underrun
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = VSYNC_W + V_BACK + V_ACTIVE + V_FRONT;
    localparam int V_ACT0  = VSYNC_W + V_BACK;
    localparam int V_ACT1  = V_ACT0 + V_ACTIVE;
    localparam int PW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int LW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    generate
        if ((H_ACTIVE * V_ACTIVE) % 8 != 0) begin : g_bad_geometry
            $error("ddr2dvp_stream: H_ACTIVE*V_ACTIVE must be a multiple of 8");
        end
    endgenerate

    typedef enum logic {S_IDLE, S_FRAME} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_pix;
    logic [LW-1:0]   r_line;
    logic [63:0]     r_word;
    logic [2:0]      r_idx;
    logic            r_full;

    logic            w_tick;
    logic            w_pix_last;
    logic            w_line_last;
    logic            w_frame_end;
    logic            w_vsync;
    logic            w_active;
    logic            w_first;
    logic            w_last;
    logic            w_consume;
    logic            w_rd_ready;
    logic            w_load;
    logic [7:0]      w_byte;

    // A tick is a pixel slot being emitted; in IDLE the enabling tick is pixel (0,0).
    assign w_tick      = pix_ce && ((r_state == S_FRAME) || enable);
    assign w_pix_last  = (r_pix == PW'(H_TOTAL - 1));
    assign w_line_last = (r_line == LW'(V_TOTAL - 1));
    assign w_frame_end = w_tick && w_pix_last && w_line_last;

    assign w_vsync  = (r_line < LW'(VSYNC_W));
    assign w_active = w_tick && (r_line >= LW'(V_ACT0)) && (r_line < LW'(V_ACT1))
                      && (r_pix < PW'(H_ACTIVE));
    assign w_first  = w_active && (r_line == LW'(V_ACT0)) && (r_pix == '0);
    assign w_last   = w_active && (r_line == LW'(V_ACT1 - 1)) && (r_pix == PW'(H_ACTIVE - 1));

    // Accepting a new word while byte 7 drains keeps back-to-back words bubble-free.
    assign w_consume   = w_active && r_full;
    assign w_rd_ready  = !reset && (!r_full || (w_consume && (r_idx == 3'd7)));
    assign w_load      = rd.rd_valid && w_rd_ready;
    assign rd.rd_ready = w_rd_ready;
    assign w_byte      = r_word[{r_idx, 3'b000} +: 8];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (pix_ce && enable) w_state_nxt = S_FRAME;
            S_FRAME: if (w_frame_end && !enable) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pix   <= '0;
            r_line  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_tick) begin
                if (w_pix_last) begin
                    r_pix  <= '0;
                    r_line <= w_line_last ? '0 : r_line + 1'b1;
                end else begin
                    r_pix <= r_pix + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_full <= 1'b0;
            r_idx  <= 3'd0;
        end else if (w_load) begin
            r_full <= 1'b1;
            r_idx  <= 3'd0;
        end else if (w_consume) begin
            r_idx <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_load) r_word <= rd.rd_data;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            VSYNC       <= 1'b0;
            HREF        <= 1'b0;
            D           <= 8'd0;
            SOF         <= 1'b0;
            EOF         <= 1'b0;
            count_frame <= 8'd0;
            underrun    <= 1'b0;
        end else begin
            SOF <= w_first;
            EOF <= w_last;
            if (pix_ce) begin
                VSYNC <= w_tick && w_vsync;
                HREF  <= w_active;
                D     <= w_consume ? w_byte : 8'd0;
            end
            if (w_tick && (r_pix == '0) && (r_line == '0)) count_frame <= count_frame + 8'd1;
            if (w_active && !r_full) underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr2dvp_stream.sv
// Directed bench for ddr2dvp_stream using a 16x2 active frame (20 ticks/line, 100 ticks/frame).
module tb_ddr2dvp_stream;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       enable;
    logic       pix_ce;
    logic       VSYNC, HREF, SOF, EOF, underrun;
    logic [7:0] D, count_frame;

    int n_checks = 0;
    int n_fail   = 0;
    int widx     = 0;
    int nwords   = 0;
    bit src_on   = 1'b0;
    logic rdy_seen;

    always #5 clk_sys = ~clk_sys;

    ddr2dvp_stream_if bus();

    ddr2dvp_stream #(
        .H_ACTIVE(16), .H_BLANK(4), .V_ACTIVE(2),
        .VSYNC_W(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .enable      (enable),
        .pix_ce      (pix_ce),
        .rd          (bus.slave),
        .VSYNC       (VSYNC),
        .HREF        (HREF),
        .D           (D),
        .SOF         (SOF),
        .EOF         (EOF),
        .count_frame (count_frame),
        .underrun    (underrun)
    );

    // Word i holds bytes 8i..8i+7 (mod 256), byte 0 in the low bits.
    function automatic logic [63:0] word_of(input int i);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'((8 * i + k) & 255);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic ce);
        logic xfer;
        pix_ce       = ce;
        bus.rd_valid = src_on && (widx < nwords);
        bus.rd_data  = word_of(widx);
        #1;
        xfer     = bus.rd_valid && bus.rd_ready;
        rdy_seen = bus.rd_ready;
        @(posedge clk_sys);
        if (xfer) widx++;
        #1;
    endtask

    function automatic bit href_at(input int t);
        return ((t >= 40) && (t < 56)) || ((t >= 60) && (t < 76));
    endfunction

    // Byte count offset base for a fully fed frame.
    function automatic int dexp_std(input int t, input int base);
        if ((t >= 40) && (t < 56)) return (base + t - 40) & 255;
        if ((t >= 60) && (t < 76)) return (base + t - 44) & 255;
        return 0;
    endfunction

    task automatic check_tick(input string s, input int t, input int dexp,
                              input bit chk_d, input bit chk_se);
        chk($sformatf("%s_vsync_t%0d", s, t), 32'(VSYNC), (t < 20) ? 1 : 0);
        chk($sformatf("%s_href_t%0d", s, t), 32'(HREF), href_at(t) ? 1 : 0);
        if (chk_d)  chk($sformatf("%s_d_t%0d", s, t), 32'(D), dexp);
        if (chk_se) begin
            chk($sformatf("%s_sof_t%0d", s, t), 32'(SOF), (t == 40) ? 1 : 0);
            chk($sformatf("%s_eof_t%0d", s, t), 32'(EOF), (t == 75) ? 1 : 0);
        end
    endtask

    task automatic check_zero(input string s);
        chk({s, "_vsync"}, 32'(VSYNC), 0);
        chk({s, "_href"},  32'(HREF), 0);
        chk({s, "_d"},     32'(D), 0);
        chk({s, "_sof"},   32'(SOF), 0);
        chk({s, "_eof"},   32'(EOF), 0);
        chk({s, "_cnt"},   32'(count_frame), 0);
        chk({s, "_undr"},  32'(underrun), 0);
    endtask

    task automatic do_reset(input string s);
        reset = 1'b1;
        cyc(1'b0);
        chk({s, "_rdy_in_reset"}, 32'(rdy_seen), 0);
        cyc(1'b0);
        check_zero(s);
        reset = 1'b0;
    endtask

    initial begin
        int dexp;
        logic ev, eh;
        logic [7:0] ed;
        reset        = 1'b1;
        enable       = 1'b0;
        pix_ce       = 1'b0;
        bus.rd_valid = 1'b0;
        bus.rd_data  = '0;

        // Power-up reset with the source already offering data.
        widx = 0; nwords = 4; src_on = 1'b1;
        do_reset("rst0");
        cyc(1'b0);
        cyc(1'b0);

        // 1 + 4: continuous pix_ce, enable dropped mid-frame at tick 50.
        enable = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if (t == 50) enable = 1'b0;
            cyc(1'b1);
            check_tick("s1", t, dexp_std(t, 0), 1'b1, 1'b1);
            if (t == 0) chk("s1_cnt_t0", 32'(count_frame), 1);
        end
        chk("s1_underrun", 32'(underrun), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1);
            chk($sformatf("s4_idle_vsync_%0d", i), 32'(VSYNC), 0);
            chk($sformatf("s4_idle_href_%0d", i),  32'(HREF), 0);
            chk($sformatf("s4_idle_d_%0d", i),     32'(D), 0);
            chk($sformatf("s4_idle_cnt_%0d", i),   32'(count_frame), 1);
        end

        // 2: pix_ce every third cycle; outputs hold, SOF/EOF single-cycle.
        do_reset("rst2");
        widx = 0; nwords = 4;
        cyc(1'b0);
        enable = 1'b1;
        for (int t = 0; t < 100; t++) begin
            cyc(1'b1);
            if (t == 1) enable = 1'b0;
            dexp = dexp_std(t, 0);
            check_tick("s2", t, dexp, 1'b1, 1'b1);
            if (t == 0) chk("s2_cnt_t0", 32'(count_frame), 1);
            ev = (t < 20); eh = href_at(t); ed = 8'(dexp);
            for (int j = 0; j < 2; j++) begin
                cyc(1'b0);
                chk($sformatf("s2_hold_vsync_t%0d", t), 32'(VSYNC), 32'(ev));
                chk($sformatf("s2_hold_href_t%0d", t),  32'(HREF), 32'(eh));
                chk($sformatf("s2_hold_d_t%0d", t),     32'(D), 32'(ed));
                chk($sformatf("s2_gap_sof_t%0d", t),    32'(SOF), 0);
                chk($sformatf("s2_gap_eof_t%0d", t),    32'(EOF), 0);
            end
        end
        chk("s2_underrun", 32'(underrun), 0);

        // 3: source withheld until tick 48; underrun sticks into the next frame.
        do_reset("rst3");
        widx = 0; nwords = 4; src_on = 1'b0;
        enable = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if (t == 48) src_on = 1'b1;
            cyc(1'b1);
            if ((t >= 49) && (t < 56))      dexp = t - 49;
            else if ((t >= 60) && (t < 76)) dexp = t - 53;
            else                            dexp = 0;
            check_tick("s3", t, dexp, 1'b1, 1'b0);
            if (t == 39) chk("s3_undr_t39", 32'(underrun), 0);
            if (t == 40) chk("s3_undr_t40", 32'(underrun), 1);
        end
        for (int t = 0; t < 45; t++) begin
            cyc(1'b1);
            check_tick("s3f2", t, 0, 1'b0, 1'b0);
            chk($sformatf("s3f2_undr_t%0d", t), 32'(underrun), 1);
            if (t == 0) chk("s3f2_cnt", 32'(count_frame), 2);
        end

        // 5: reset mid-word at tick 45; restart must begin with the new word's byte 0.
        do_reset("rst5");
        widx = 0; nwords = 8; src_on = 1'b1;
        cyc(1'b0);
        enable = 1'b1;
        for (int t = 0; t < 45; t++) begin
            cyc(1'b1);
            check_tick("s5a", t, dexp_std(t, 0), 1'b1, 1'b1);
        end
        widx  = 4;
        reset = 1'b1;
        cyc(1'b1);
        chk("s5_rdy_in_reset", 32'(rdy_seen), 0);
        check_zero("s5_rst");
        reset = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (t == 50) enable = 1'b0;
            cyc(1'b1);
            check_tick("s5b", t, dexp_std(t, 32'h20), 1'b1, 1'b1);
            if (t == 0) chk("s5b_cnt_t0", 32'(count_frame), 1);
        end
        chk("s5_underrun", 32'(underrun), 0);

        // 6: 256 back-to-back frames; count_frame wraps to 0.
        do_reset("rst6");
        widx = 0; nwords = 2000; src_on = 1'b1;
        cyc(1'b0);
        enable = 1'b1;
        for (int f = 0; f < 256; f++) begin
            for (int t = 0; t < 100; t++) begin
                if ((f == 255) && (t == 50)) enable = 1'b0;
                cyc(1'b1);
                if (t == 0) begin
                    chk($sformatf("s6_cnt_f%0d", f), 32'(count_frame), (f + 1) & 255);
                    chk($sformatf("s6_vsync_f%0d", f), 32'(VSYNC), 1);
                end
                if (t == 40) chk($sformatf("s6_d40_f%0d", f), 32'(D), (32 * f) & 255);
                if (t == 99) chk($sformatf("s6_href99_f%0d", f), 32'(HREF), 0);
            end
        end
        cyc(1'b1);
        chk("s6_end_cnt",   32'(count_frame), 0);
        chk("s6_end_vsync", 32'(VSYNC), 0);
        chk("s6_end_undr",  32'(underrun), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
